// File: rtl/manhattan_update_sequencer.sv
// Walks the weight/error memories one entry at a time, drives the combinational
// Manhattan update block and writes each updated weight back in ascending order.
module manhattan_update_sequencer #(
  parameter int BIT_WIDTH   = 32,
  parameter int EXTRA_BIT   = 2,
  parameter int NUM_WEIGHTS = 16,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [BIT_WIDTH+EXTRA_BIT-1:0] eta,
  output logic                           busy,
  output logic                           done,
  output logic                           exc_flag,
  output logic [ADDR_WIDTH:0]            skip_count,
  output logic                           mem_rd_en,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  input  logic [BIT_WIDTH+EXTRA_BIT-1:0] w_rd_data,
  input  logic [BIT_WIDTH+EXTRA_BIT-1:0] err_rd_data,
  output logic                           man_enable,
  output logic [BIT_WIDTH+EXTRA_BIT-1:0] man_old_weight,
  output logic [BIT_WIDTH+EXTRA_BIT-1:0] man_diff_error,
  output logic [BIT_WIDTH+EXTRA_BIT-1:0] man_eta,
  input  logic [BIT_WIDTH+EXTRA_BIT-1:0] man_updated_weight,
  output logic                           w_wr_en,
  output logic [BIT_WIDTH+EXTRA_BIT-1:0] w_wr_data
);

  localparam int DW = BIT_WIDTH + EXTRA_BIT;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WEIGHTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WT,
    S_CALC,
    S_WR,
    S_DONE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DW-1:0]           eta_reg;

  // The latched eta is the Manhattan block's eta, so mid-pass eta changes are invisible.
  assign man_eta = eta_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      addr           <= '0;
      eta_reg        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      exc_flag       <= 1'b0;
      skip_count     <= '0;
      mem_rd_en      <= 1'b0;
      mem_addr       <= '0;
      man_enable     <= 1'b0;
      man_old_weight <= '0;
      man_diff_error <= '0;
      w_wr_en        <= 1'b0;
      w_wr_data      <= '0;
    end else begin
      mem_rd_en  <= 1'b0;
      w_wr_en    <= 1'b0;
      done       <= 1'b0;
      man_enable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            eta_reg    <= eta;
            addr       <= '0;
            mem_addr   <= '0;
            exc_flag   <= 1'b0;
            skip_count <= '0;
            busy       <= 1'b1;
            mem_rd_en  <= 1'b1;
            state      <= S_RD;
          end
        end
        S_RD: begin
          state <= S_WT;
        end
        S_WT: begin
          // Operands go straight into the registers feeding the Manhattan block,
          // so they are stable for the whole CALC/WR window.
          man_old_weight <= w_rd_data;
          man_diff_error <= err_rd_data;
          man_enable     <= ~err_rd_data[DW-1];
          state          <= S_CALC;
        end
        S_CALC: begin
          case (man_diff_error[DW-1:DW-2])
            2'b01: w_wr_data <= man_updated_weight;
            2'b00: begin
              w_wr_data  <= man_old_weight;
              skip_count <= skip_count + 1'b1;
            end
            default: begin
              w_wr_data <= man_old_weight;
              exc_flag  <= 1'b1;
            end
          endcase
          w_wr_en <= 1'b1;
          state   <= S_WR;
        end
        S_WR: begin
          if (addr == LAST_ADDR) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            addr      <= addr + 1'b1;
            mem_addr  <= addr + 1'b1;
            mem_rd_en <= 1'b1;
            state     <= S_RD;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/manhattan_update_sequencer.md
Name: manhattan_update_sequencer

Overview:
- Sequential controller that walks a weight memory and its matching differentiated-error memory, one entry at a time.
- For each entry it drives the combinational Manhattan update block (W + eta·sgn(err)), captures the updated weight and writes it back.
- Sits directly upstream of the Manhattan block and owns its Old_Weights, Differentiated_Error, eta and Manhattan_Enable inputs.
- One training iteration's weight update = one start/done transaction.

Parameters:
- BIT_WIDTH, 32, IEEE-style float payload width.
- EXTRA_BIT, 2, FloPoCo exception bits prepended (00 zero, 01 normal, 10 inf, 11 NaN).
- NUM_WEIGHTS, 16, number of weights updated per transaction (≥1).
- ADDR_WIDTH, 4, memory address width (2^ADDR_WIDTH ≥ NUM_WEIGHTS).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a pass; sampled only in IDLE.
- eta  in  BIT_WIDTH+EXTRA_BIT  learning step, latched on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of pass.
- exc_flag  out  1  sticky: some error word had exception 10/11 this pass.
- skip_count  out  ADDR_WIDTH+1  entries with zero error (exception 00) in last pass.
- mem_rd_en  out  1  read strobe, shared by weight and error memories.
- mem_addr  out  ADDR_WIDTH  read/write address.
- w_rd_data  in  BIT_WIDTH+EXTRA_BIT  weight read data, valid 1 cycle after mem_rd_en.
- err_rd_data  in  BIT_WIDTH+EXTRA_BIT  error read data, same latency.
- man_enable  out  1  drives Manhattan_Enable.
- man_old_weight  out  BIT_WIDTH+EXTRA_BIT  drives Old_Weights.
- man_diff_error  out  BIT_WIDTH+EXTRA_BIT  drives Differentiated_Error.
- man_eta  out  BIT_WIDTH+EXTRA_BIT  drives eta (latched copy).
- man_updated_weight  in  BIT_WIDTH+EXTRA_BIT  Updated_Weights from Manhattan block.
- w_wr_en  out  1  weight write strobe.
- w_wr_data  out  BIT_WIDTH+EXTRA_BIT  write-back value.

Behaviour:
- Reset (sync): state=IDLE. All outputs 0, including exc_flag, skip_count and the man_* buses. Internal address, eta and data registers cleared. Reset mid-pass abandons the pass: no further writes, no done.
- FSM states: IDLE, RD, WT, CALC, WR, DONE. All outputs are registered/state-decoded; no combinational path from inputs to outputs except man_updated_weight → w_wr_data capture.
- IDLE:
  - On start=1: latch eta, addr←0, clear exc_flag and skip_count, go to RD.
  - start while busy is ignored.
- RD: mem_rd_en=1, mem_addr=addr → WT.
- WT: read data valid. Register w_rd_data→old_w and err_rd_data→err. Classify err by exception bits → CALC.
- CALC: man_old_weight/man_diff_error/man_eta driven from registers (held stable from entering CALC through WR).
  - err exception 01: man_enable=1, wr_data←man_updated_weight.
  - err exception 00: man_enable=1, wr_data←old_w, skip_count+1.
  - err exception 1x: man_enable=0, wr_data←old_w, exc_flag←1.
  - → WR.
- WR: w_wr_en=1, mem_addr=addr, w_wr_data=wr_data.
  - If addr==NUM_WEIGHTS-1 → DONE.
  - Else addr+1 → RD.
- DONE: done=1 for exactly one cycle → IDLE. skip_count and exc_flag hold until next accepted start.
- Latency: start accepted at cycle 0 → first write at cycle 4 → k-th write (k=1..N) at cycle 4k → done at cycle 4N+1. busy high cycles 1..4N+1.
- Exactly one write per entry, in ascending address order. Read and write never occur in the same cycle.
- NUM_WEIGHTS=1: RD, WT, CALC, WR, DONE, with done at cycle 5.
- Address never exceeds NUM_WEIGHTS-1; no wrap.
- eta changes after start have no effect until the next pass.

Test Plan:
- N=4, all weights {01,3F800000} (1.0), all errors {01,40000000} (+2.0), eta {01,3F000000}; real Manhattan block attached → four writes at cycles 4,8,12,16, each writing the Manhattan result for 1.0+0.5 (+ its epsilon term). done at cycle 17, skip_count=0, exc_flag=0.
- Error at addr 2 all-zero 34'h0 → write at addr 2 equals old weight exactly, skip_count=1, others updated.
- Error at addr 1 = {11,7FC00000} (NaN) → man_enable=0 in that CALC, old weight written back, exc_flag=1 after pass; cleared on next start.
- Assert start in cycles 3 and 9 mid-pass → ignored; only one done, at cycle 17.
- Assert rst at cycle 10 → next cycle all outputs 0, no further w_wr_en, no done. Fresh start runs a full pass correctly.
- Change eta at cycle 2 → man_eta keeps the start-time value for the whole pass.
